bsg_counter_multi_updown_step: RTL and testbench

//  Bank of els_p independent up/down counters. Each counter has a synchronous

---
 rtl/bsg_counter_pkg.sv | 28 ++
 rtl/bsg_counter_updown_step_chan.sv | 103 ++++++++++
 rtl/bsg_counter_multi_updown_step.sv | 75 +++++++
 tb/tb_bsg_counter_multi_updown_step.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_counter_pkg.sv
// Shared types and helpers for the step up/down counter bank.
//   bsg_cnt_op_e      : per-channel operation selected for the current cycle
//   bsg_cnt_op_decode : priority decode set > (up xor down, nonzero step) > hold
package bsg_counter_pkg;

  typedef enum logic [1:0] {
    e_cnt_hold,
    e_cnt_set,
    e_cnt_up,
    e_cnt_down
  } bsg_cnt_op_e;

  // A zero step or conflicting up/down requests collapse to hold.
  function automatic bsg_cnt_op_e bsg_cnt_op_decode(input logic set,
                                                    input logic up,
                                                    input logic down,
                                                    input logic step_nz);
    bsg_cnt_op_e op;
    op = e_cnt_hold;
    if (set) begin
      op = e_cnt_set;
    end else if (step_nz && (up ^ down)) begin
      op = up ? e_cnt_up : e_cnt_down;
    end
    return op;
  endfunction

endpackage

// File: rtl/bsg_counter_updown_step_chan.sv
// One counter channel: op decode, next-value arithmetic, count and limit flops.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   set_i, set_val_i : synchronous load (clamped to max_val_p)
//   up_i, down_i     : step request direction
//   step_i           : step magnitude
//   count_o          : registered count
//   at_zero_o        : combinational count == 0
//   at_max_o         : combinational count == max_val_p
//   limit_o          : registered pulse, last update wrapped/saturated/clamped
module bsg_counter_updown_step_chan
  import bsg_counter_pkg::*;
#(
  parameter int unsigned width_p      = 8,
  parameter int unsigned step_width_p = 4,
  parameter int unsigned max_val_p    = 255,
  parameter int unsigned saturate_p   = 0,
  parameter int unsigned reset_val_p  = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    set_i,
  input  logic [width_p-1:0]      set_val_i,
  input  logic                    up_i,
  input  logic                    down_i,
  input  logic [step_width_p-1:0] step_i,
  output logic [width_p-1:0]      count_o,
  output logic                    at_zero_o,
  output logic                    at_max_o,
  output logic                    limit_o
);

  // One extra bit holds count+step and count+range without overflow.
  localparam int unsigned ew_lp = width_p + 1;
  localparam logic [ew_lp-1:0]   max_e_lp   = ew_lp'(max_val_p);
  localparam logic [ew_lp-1:0]   range_e_lp = ew_lp'(max_val_p) + ew_lp'(1);
  localparam logic [width_p-1:0] max_w_lp   = width_p'(max_val_p);
  localparam logic [width_p-1:0] reset_w_lp = width_p'(reset_val_p);

  logic [width_p-1:0] count_r, count_n;
  logic               limit_r, limit_n;
  bsg_cnt_op_e        op;
  logic [ew_lp-1:0]   cnt_e, step_e, set_e, sum_e;

  assign cnt_e  = {1'b0, count_r};
  assign step_e = ew_lp'(step_i);
  assign set_e  = {1'b0, set_val_i};
  assign sum_e  = cnt_e + step_e;

  // Next-state arithmetic for the selected operation.
  always_comb begin
    count_n = count_r;
    limit_n = 1'b0;
    op      = bsg_cnt_op_decode(set_i, up_i, down_i, |step_i);
    case (op)
      e_cnt_set: begin
        if (set_e > max_e_lp) begin
          count_n = max_w_lp;
          limit_n = 1'b1;
        end else begin
          count_n = set_val_i;
        end
      end
      e_cnt_up: begin
        if (sum_e > max_e_lp) begin
          limit_n = 1'b1;
          count_n = (saturate_p != 0) ? max_w_lp : width_p'(sum_e - range_e_lp);
        end else begin
          count_n = width_p'(sum_e);
        end
      end
      e_cnt_down: begin
        if (step_e > cnt_e) begin
          limit_n = 1'b1;
          count_n = (saturate_p != 0) ? '0 : width_p'(cnt_e + range_e_lp - step_e);
        end else begin
          count_n = width_p'(cnt_e - step_e);
        end
      end
      default: begin
        count_n = count_r;
        limit_n = 1'b0;
      end
    endcase
  end

  // Count and limit-pulse registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= reset_w_lp;
      limit_r <= 1'b0;
    end else begin
      count_r <= count_n;
      limit_r <= limit_n;
    end
  end

  assign count_o   = count_r;
  assign limit_o   = limit_r;
  assign at_zero_o = (count_r == '0);
  assign at_max_o  = (count_r == max_w_lp);

endmodule

// File: rtl/bsg_counter_multi_updown_step.sv
// Bank of els_p independent up/down counters with variable step, wrap or
// saturate at max_val_p, clamped load, and registered limit-event pulses.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   set_i/set_val_i  : per-channel load strobe and packed load values
//   up_i/down_i      : per-channel direction requests
//   step_i           : step magnitude shared by all channels
//   count_o          : packed registered counts (channel i = [i*width_p +: width_p])
//   at_zero_o/at_max_o : combinational terminal-value flags
//   limit_o          : registered per-channel wrap/saturate/clamp pulse
module bsg_counter_multi_updown_step #(
  parameter int unsigned els_p        = 4,
  parameter int unsigned width_p      = 8,
  parameter int unsigned step_width_p = 4,
  parameter int unsigned max_val_p    = (1 << width_p) - 1,
  parameter int unsigned saturate_p   = 0,
  parameter int unsigned reset_val_p  = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           set_i,
  input  logic [els_p*width_p-1:0]   set_val_i,
  input  logic [els_p-1:0]           up_i,
  input  logic [els_p-1:0]           down_i,
  input  logic [step_width_p-1:0]    step_i,
  output logic [els_p*width_p-1:0]   count_o,
  output logic [els_p-1:0]           at_zero_o,
  output logic [els_p-1:0]           at_max_o,
  output logic [els_p-1:0]           limit_o
);

  // Parameter legality; a single wrap correction relies on the step bound.
  if (els_p < 1) begin : g_bad_els
    $error("els_p must be at least 1");
  end
  if (width_p < 1) begin : g_bad_width
    $error("width_p must be at least 1");
  end
  if (step_width_p > width_p) begin : g_bad_step_width
    $error("step_width_p must not exceed width_p");
  end
  if (reset_val_p > max_val_p) begin : g_bad_reset_val
    $error("reset_val_p must not exceed max_val_p");
  end
  if (64'(max_val_p) >= (64'(1) << width_p)) begin : g_bad_max_val
    $error("max_val_p must fit in width_p bits");
  end
  if (((64'(1) << step_width_p) - 64'(1)) > (64'(max_val_p) + 64'(1))) begin : g_bad_step_range
    $error("largest step must not exceed max_val_p+1");
  end

  // One channel instance per counter; ports are sliced from the packed buses.
  for (genvar i = 0; i < int'(els_p); i++) begin : g_chan
    bsg_counter_updown_step_chan #(
      .width_p      (width_p),
      .step_width_p (step_width_p),
      .max_val_p    (max_val_p),
      .saturate_p   (saturate_p),
      .reset_val_p  (reset_val_p)
    ) u_chan (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .set_i     (set_i[i]),
      .set_val_i (set_val_i[i*width_p +: width_p]),
      .up_i      (up_i[i]),
      .down_i    (down_i[i]),
      .step_i    (step_i),
      .count_o   (count_o[i*width_p +: width_p]),
      .at_zero_o (at_zero_o[i]),
      .at_max_o  (at_max_o[i]),
      .limit_o   (limit_o[i])
    );
  end

endmodule

// File: tb/tb_bsg_counter_multi_updown_step.sv
// Bench for bsg_counter_multi_updown_step: three instances (wrap at 9,
// saturate at 9, full-range wrap at 255) share stimulus and are tracked by
// an arithmetic reference model.
module tb_bsg_counter_multi_updown_step;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  set_i;
  logic [31:0] set_val_i;
  logic [3:0]  up_i;
  logic [3:0]  down_i;
  logic [2:0]  step3;
  logic [3:0]  step4;

  logic [31:0] count_wrap, count_sat, count_full;
  logic [3:0]  zero_wrap, zero_sat, zero_full;
  logic [3:0]  max_wrap, max_sat, max_full;
  logic [3:0]  limit_wrap, limit_sat, limit_full;

  int total = 0;
  int bad   = 0;

  // Reference state: [dut][channel]; dut 0 = wrap9, 1 = sat9, 2 = full255.
  localparam int maxv_c [3] = '{9, 9, 255};
  localparam bit sat_c  [3] = '{1'b0, 1'b1, 1'b0};
  localparam int rstv_c [3] = '{5, 5, 0};
  int m [3][4];
  bit l [3][4];

  always #5 clk_i = ~clk_i;

  bsg_counter_multi_updown_step #(
    .els_p(4), .width_p(8), .step_width_p(3), .max_val_p(9),
    .saturate_p(0), .reset_val_p(5)
  ) u_wrap (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .set_i(set_i), .set_val_i(set_val_i),
    .up_i(up_i), .down_i(down_i), .step_i(step3), .count_o(count_wrap),
    .at_zero_o(zero_wrap), .at_max_o(max_wrap), .limit_o(limit_wrap)
  );

  bsg_counter_multi_updown_step #(
    .els_p(4), .width_p(8), .step_width_p(3), .max_val_p(9),
    .saturate_p(1), .reset_val_p(5)
  ) u_sat (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .set_i(set_i), .set_val_i(set_val_i),
    .up_i(up_i), .down_i(down_i), .step_i(step3), .count_o(count_sat),
    .at_zero_o(zero_sat), .at_max_o(max_sat), .limit_o(limit_sat)
  );

  bsg_counter_multi_updown_step #(
    .els_p(4), .width_p(8), .step_width_p(4), .max_val_p(255),
    .saturate_p(0), .reset_val_p(0)
  ) u_full (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .set_i(set_i), .set_val_i(set_val_i),
    .up_i(up_i), .down_i(down_i), .step_i(step4), .count_o(count_full),
    .at_zero_o(zero_full), .at_max_o(max_full), .limit_o(limit_full)
  );

  // Reference behaviour: signed raw result, then clamp or modulo.
  function automatic void model_next(input int cnt, input bit set, input int setv,
                                     input bit up, input bit down, input int step,
                                     input int maxv, input bit sat,
                                     output int nc, output bit lim);
    int raw;
    nc  = cnt;
    lim = 1'b0;
    if (set) begin
      lim = (setv > maxv);
      nc  = lim ? maxv : setv;
    end else if ((up != down) && (step != 0)) begin
      raw = up ? cnt + step : cnt - step;
      lim = (raw < 0) || (raw > maxv);
      if (!lim)     nc = raw;
      else if (sat) nc = (raw < 0) ? 0 : maxv;
      else          nc = (raw + maxv + 1) % (maxv + 1);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < 4; ch++) begin
        m[d][ch] = rstv_c[d];
        l[d][ch] = 1'b0;
      end
  endfunction

  task automatic idle();
    set_i = '0; set_val_i = '0; up_i = '0; down_i = '0; step3 = '0; step4 = '0;
  endtask

  // Advance one clock, keeping the model in step; returns 1 ns after the edge.
  task automatic tick();
    int nxt [3][4];
    bit nl  [3][4];
    int nc;
    bit lm;
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < 4; ch++) begin
        model_next(m[d][ch], set_i[ch], int'(set_val_i[ch*8 +: 8]), up_i[ch], down_i[ch],
                   (d == 2) ? int'(step4) : int'(step3), maxv_c[d], sat_c[d], nc, lm);
        nxt[d][ch] = nc;
        nl[d][ch]  = lm;
      end
    @(posedge clk_i);
    if (reset_n_i) begin
      for (int d = 0; d < 3; d++)
        for (int ch = 0; ch < 4; ch++) begin
          m[d][ch] = nxt[d][ch];
          l[d][ch] = nl[d][ch];
        end
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    model_reset();
    #1;
    total++; if (count_wrap !== {4{8'd5}}) begin bad++; $display("FAIL reset_count_wrap got=%h exp=05050505", count_wrap); end
    total++; if (count_full !== 32'd0) begin bad++; $display("FAIL reset_count_full got=%h exp=0", count_full); end
    total++; if ((limit_wrap | limit_sat | limit_full) !== 4'd0) begin bad++; $display("FAIL reset_limit got=%b exp=0", limit_wrap | limit_sat | limit_full); end
    tick();
    reset_n_i = 1'b1;
    up_i = 4'hF; step3 = 3'd2; step4 = 4'd2;
    tick(); tick(); tick();
    total++; if (count_wrap[7:0] !== 8'd1 || limit_wrap[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_wrap got=%0d/%b exp=1/1", count_wrap[7:0], limit_wrap[0]); end
    // Assert reset between edges: must take effect without a clock.
    #2 reset_n_i = 1'b0;
    model_reset();
    #1;
    total++; if (count_wrap !== {4{8'd5}} || count_sat !== {4{8'd5}}) begin bad++; $display("FAIL async_reset_count got=%h/%h exp=05050505", count_wrap, count_sat); end
    total++; if (limit_wrap !== 4'd0 || count_full !== 32'd0) begin bad++; $display("FAIL async_reset_limit got=%b/%h exp=0/0", limit_wrap, count_full); end
    tick();
    total++; if (count_wrap !== {4{8'd5}}) begin bad++; $display("FAIL held_reset_count got=%h exp=05050505", count_wrap); end
    reset_n_i = 1'b1;
    idle();
    tick();
    total++; if (count_sat !== {4{8'd5}} || limit_sat !== 4'd0) begin bad++; $display("FAIL post_reset got=%h/%b exp=05050505/0", count_sat, limit_sat); end
  endtask

  task automatic test_wrap();
    idle();
    set_i = 4'b0011; set_val_i = {16'd0, 8'd250, 8'd8};
    tick();
    total++; if (count_wrap[7:0] !== 8'd8 || limit_wrap[0] !== 1'b0) begin bad++; $display("FAIL wrap_set got=%0d/%b exp=8/0", count_wrap[7:0], limit_wrap[0]); end
    set_i = '0; up_i = 4'b0011; step3 = 3'd3; step4 = 4'd7;
    tick();
    total++; if (count_wrap[7:0] !== 8'd1 || limit_wrap[0] !== 1'b1) begin bad++; $display("FAIL wrap_up got=%0d/%b exp=1/1", count_wrap[7:0], limit_wrap[0]); end
    total++; if (count_full[15:8] !== 8'd1 || limit_full[1] !== 1'b1) begin bad++; $display("FAIL full_wrap_up got=%0d/%b exp=1/1", count_full[15:8], limit_full[1]); end
    total++; if (count_full[7:0] !== 8'd15 || limit_full[0] !== 1'b0) begin bad++; $display("FAIL full_up got=%0d/%b exp=15/0", count_full[7:0], limit_full[0]); end
    up_i = '0;
    tick();
    total++; if (count_wrap[7:0] !== 8'd1 || limit_wrap[0] !== 1'b0) begin bad++; $display("FAIL wrap_pulse_end got=%0d/%b exp=1/0", count_wrap[7:0], limit_wrap[0]); end
    down_i = 4'b0001; step3 = 3'd4;
    tick();
    total++; if (count_wrap[7:0] !== 8'd7 || limit_wrap[0] !== 1'b1) begin bad++; $display("FAIL wrap_down got=%0d/%b exp=7/1", count_wrap[7:0], limit_wrap[0]); end
    idle();
    tick();
  endtask

  task automatic test_saturate();
    idle();
    set_i = 4'b0001; set_val_i = 32'd8;
    tick();
    set_i = '0; up_i = 4'b0001; step3 = 3'd3;
    tick();
    total++; if (count_sat[7:0] !== 8'd9 || limit_sat[0] !== 1'b1 || max_sat[0] !== 1'b1) begin bad++; $display("FAIL sat_up got=%0d/%b/%b exp=9/1/1", count_sat[7:0], limit_sat[0], max_sat[0]); end
    tick();
    total++; if (count_sat[7:0] !== 8'd9 || limit_sat[0] !== 1'b1) begin bad++; $display("FAIL sat_up_again got=%0d/%b exp=9/1", count_sat[7:0], limit_sat[0]); end
    up_i = '0; set_i = 4'b0001; set_val_i = 32'd2;
    tick();
    total++; if (count_sat[7:0] !== 8'd2 || limit_sat[0] !== 1'b0) begin bad++; $display("FAIL sat_set got=%0d/%b exp=2/0", count_sat[7:0], limit_sat[0]); end
    set_i = '0; down_i = 4'b0001; step3 = 3'd5;
    tick();
    total++; if (count_sat[7:0] !== 8'd0 || limit_sat[0] !== 1'b1 || zero_sat[0] !== 1'b1) begin bad++; $display("FAIL sat_down got=%0d/%b/%b exp=0/1/1", count_sat[7:0], limit_sat[0], zero_sat[0]); end
    idle();
    tick();
    total++; if (limit_sat[0] !== 1'b0) begin bad++; $display("FAIL sat_pulse_end got=%b exp=0", limit_sat[0]); end
  endtask

  task automatic test_priority();
    idle();
    set_i = 4'b0100; up_i = 4'b0100; down_i = 4'b0100; set_val_i = 32'h0004_0000; step3 = 3'd3;
    tick();
    total++; if (count_wrap[23:16] !== 8'd4 || limit_wrap[2] !== 1'b0) begin bad++; $display("FAIL prio_set got=%0d/%b exp=4/0", count_wrap[23:16], limit_wrap[2]); end
    set_i = '0;
    tick();
    total++; if (count_wrap[23:16] !== 8'd4 || limit_wrap[2] !== 1'b0) begin bad++; $display("FAIL prio_updown_hold got=%0d/%b exp=4/0", count_wrap[23:16], limit_wrap[2]); end
    down_i = '0; step3 = 3'd0; step4 = 4'd0;
    tick();
    total++; if (count_wrap[23:16] !== 8'd4 || count_full[23:16] !== 8'd4 || limit_wrap[2] !== 1'b0) begin bad++; $display("FAIL prio_step0 got=%0d/%0d exp=4/4", count_wrap[23:16], count_full[23:16]); end
    step3 = 3'd2;
    tick();
    total++; if (count_wrap[23:16] !== 8'd6) begin bad++; $display("FAIL prio_step2 got=%0d exp=6", count_wrap[23:16]); end
    idle();
  endtask

  task automatic test_clamp();
    idle();
    set_i = 4'b1000; set_val_i = {8'd200, 24'd0};
    tick();
    total++; if (count_wrap[31:24] !== 8'd9 || limit_wrap[3] !== 1'b1 || max_wrap[3] !== 1'b1) begin bad++; $display("FAIL clamp_load got=%0d/%b/%b exp=9/1/1", count_wrap[31:24], limit_wrap[3], max_wrap[3]); end
    total++; if (count_full[31:24] !== 8'd200 || limit_full[3] !== 1'b0) begin bad++; $display("FAIL full_load got=%0d/%b exp=200/0", count_full[31:24], limit_full[3]); end
    set_val_i = {8'd6, 24'd0};
    tick();
    set_i = '0; up_i = 4'b1000; step3 = 3'd3;
    tick();
    total++; if (count_wrap[31:24] !== 8'd9 || max_wrap[3] !== 1'b1 || limit_wrap[3] !== 1'b0) begin bad++; $display("FAIL exact_max got=%0d/%b/%b exp=9/1/0", count_wrap[31:24], max_wrap[3], limit_wrap[3]); end
    up_i = '0; set_i = 4'b1000; set_val_i = {8'd5, 24'd0};
    tick();
    set_i = '0; down_i = 4'b1000; step3 = 3'd5;
    tick();
    total++; if (count_wrap[31:24] !== 8'd0 || zero_wrap[3] !== 1'b1 || limit_wrap[3] !== 1'b0) begin bad++; $display("FAIL exact_zero got=%0d/%b/%b exp=0/1/0", count_wrap[31:24], zero_wrap[3], limit_wrap[3]); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] cv;
    logic [3:0]  lv, zv, mv;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int ch = 0; ch < 4; ch++) begin
        set_i[ch]  = ($urandom_range(7) == 0);
        up_i[ch]   = 1'($urandom);
        down_i[ch] = 1'($urandom);
      end
      set_val_i = $urandom;
      step3 = 3'($urandom);
      step4 = 4'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        cv = (d == 0) ? count_wrap : (d == 1) ? count_sat : count_full;
        lv = (d == 0) ? limit_wrap : (d == 1) ? limit_sat : limit_full;
        zv = (d == 0) ? zero_wrap  : (d == 1) ? zero_sat  : zero_full;
        mv = (d == 0) ? max_wrap   : (d == 1) ? max_sat   : max_full;
        for (int ch = 0; ch < 4; ch++) begin
          total++;
          if (cv[ch*8 +: 8] !== 8'(m[d][ch]) || lv[ch] !== l[d][ch] ||
              zv[ch] !== (m[d][ch] == 0) || mv[ch] !== (m[d][ch] == maxv_c[d])) begin
            bad++;
            if (bad < 20)
              $display("FAIL rand dut%0d ch%0d cyc%0d got cnt=%0d lim=%b z=%b m=%b exp cnt=%0d lim=%b",
                       d, ch, cyc, cv[ch*8 +: 8], lv[ch], zv[ch], mv[ch], m[d][ch], l[d][ch]);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n_i = 1'b1;
    model_reset();
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_clamp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
